imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It receives a program image as a byte stream over a valid/ready handshake, packs the bytes into 32-bit words and drives word-indexed write strobes into the instruction memory's write port. While loading, it holds the processor core in reset through cpu_hold, and releases the core once the image has loaded without error. It replaces file-based preload for synthesizable and FPGA builds.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/loader_byte_packer.sv | 32 +++
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LEN_W      = 8 * LEN_BYTES;
  localparam int unsigned IDX_W      = $clog2(WORD_BYTES);
  localparam int unsigned PACK_W     = 8 * (WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/loader_byte_packer.sv
// Little-endian byte-to-word packer. word/word_full are combinational: they present
// the completed word in the same cycle the last byte is shifted in.
module loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        shift,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [IDX_W-1:0]  idx_q;
  logic [PACK_W-1:0] bytes_q;

  // Only the first three bytes need storage; the fourth comes straight from byte_in.
  assign word      = {byte_in, bytes_q};
  assign word_full = shift && (idx_q == IDX_W'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx_q   <= '0;
      bytes_q <= '0;
    end else if (shift) begin
      idx_q   <= IDX_W'(idx_q + 1'b1);
      bytes_q <= {byte_in, bytes_q[PACK_W-1:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: length-prefixed byte stream -> 32-bit word writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 65536,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [15:0]       words_loaded,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
  logic [7:0] csum_q, csum_d;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d, len_rx;
  logic [15:0]       words_d;
  logic              in_ready_d, mem_we_d, done_d, error_d, cpu_hold_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;
  logic              accept, pk_shift, pk_clear, pk_full;
  logic [31:0]       pk_word;

  assign accept   = in_valid && in_ready;
  assign len_rx   = {in_data, len_lo_q};
  assign pk_shift = accept && (state_q == S_DATA);
  assign pk_clear = (state_q == S_LEN0);

  loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .shift     (pk_shift),
    .clear     (pk_clear),
    .byte_in   (in_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  // Next-state and next-output logic; the write strobe is loaded on entry to S_WRITE.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    words_d     = words_loaded;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    if (accept && (state_q inside {S_LEN0, S_LEN1, S_DATA})) begin
      csum_d = csum_q ^ in_data;
    end
`endif
    case (state_q)
      S_LEN0: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = len_rx;
          if (32'(len_rx) > DEPTH) begin
            state_d = S_ERR;
          end else if (len_rx == '0) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (pk_full) begin
          state_d     = S_WRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(words_loaded);
          mem_wdata_d = pk_word;
        end
      end
      S_WRITE: begin
        words_d = words_loaded + 16'd1;
        state_d = (words_d == len_q) ? S_TAIL : S_DATA;
      end
      S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
`else
        state_d = S_ERR;
`endif
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_LEN0;
    endcase
    in_ready_d = (state_d inside {S_LEN0, S_LEN1, S_DATA, S_CSUM});
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    cpu_hold_d = !done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LEN0;
      len_lo_q     <= '0;
      len_q        <= '0;
      words_loaded <= '0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      words_loaded <= words_d;
      in_ready     <= in_ready_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      done         <= done_d;
      error        <= error_d;
      cpu_hold     <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built from word lists, expected writes
// are queued as bytes are sent, and a negedge monitor checks every mem_we against them.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, mem_we, done, error, cpu_hold;
  logic [7:0]        in_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [15:0]       words_loaded;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] wbuf [0:7];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .words_loaded (words_loaded),
    .done         (done),
    .error        (error),
    .cpu_hold     (cpu_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, including its cycle.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wdata, e.data);
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Present one byte and hold it until accepted; acc is the cycle count after the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int unsigned acc);
    int t;
    t = 0;
    acc = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: byte 0x%02h not accepted, in_ready=%b, expected 1", b, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int g);
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit chk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (chk) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_words_loaded", 32'(words_loaded), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Send a complete frame of n words from wbuf and check the final status.
  task automatic run_frame(input int unsigned n, input int gap, input bit bad);
    logic [15:0] len;
    logic [7:0]  x, b;
    int unsigned acc;
    bit          ovf, err;
    int          t;
    wr_t         e;
    len = 16'(n);
    ovf = (n > DEPTH);
    err = ovf || (CSUM && bad);
    x = 8'h00;
    send_byte(len[7:0], acc);  x ^= len[7:0];  idle(gap);
    send_byte(len[15:8], acc); x ^= len[15:8]; idle(gap);
    if (!ovf) begin
      for (int j = 0; j < int'(n); j++) begin
        for (int k = 0; k < 4; k++) begin
          b = wbuf[j][8*k +: 8];
          send_byte(b, acc);
          x ^= b;
          if (k == 3) begin
            e.addr = j;
            e.data = wbuf[j];
            e.cyc  = acc;
            exp_q.push_back(e);
          end
          idle(gap);
        end
      end
      if (CSUM) send_byte(bad ? (x ^ 8'h03) : x, acc);
    end
    t = 0;
    @(negedge clk);
    while (done !== 1'b1 && error !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("done", 32'(done), 32'(!err));
    check("error", 32'(error), 32'(err));
    check("cpu_hold", 32'(cpu_hold), 32'(err));
    check("words_loaded", 32'(words_loaded), ovf ? 32'd0 : n);
    check("in_ready_end", 32'(in_ready), 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int unsigned acc, n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    do_reset(1'b1);

    wbuf[0] = 32'h0000_0013;
    wbuf[1] = 32'hFFFF_FFFF;
    run_frame(2, 0, 1'b0);
    do_reset(1'b0);
    run_frame(2, 3, 1'b0);
    do_reset(1'b0);
    run_frame(0, 0, 1'b0);
    do_reset(1'b0);
    run_frame(5, 0, 1'b0);

    // Reset in the middle of a word: no write, and the next frame starts clean.
    do_reset(1'b0);
    send_byte(8'h01, acc);
    send_byte(8'h00, acc);
    send_byte(8'hAA, acc);
    send_byte(8'hBB, acc);
    idle(2);
    do_reset(1'b1);
    wbuf[0] = 32'h4433_2211;
    run_frame(1, 0, 1'b0);

    if (CSUM) begin
      wbuf[0] = 32'h0000_0013;
      wbuf[1] = 32'hFFFF_FFFF;
      do_reset(1'b0);
      run_frame(2, 0, 1'b1);
    end

    for (int i = 0; i < 25; i++) begin
      do_reset(1'b0);
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH + 1, 65535) : $urandom_range(0, DEPTH);
      for (int j = 0; j < 8; j++) wbuf[j] = $urandom;
      run_frame(n, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
